// File: rtl/tlc_pkg.sv
// Shared lamp encodings, fault codes and monitor state for the traffic-light
// controller and its downstream conflict monitor.
package tlc_pkg;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_GRN   = 3'd1;
  localparam logic [2:0] FC_ILL   = 3'd2;
  localparam logic [2:0] FC_SKIP  = 3'd3;
  localparam logic [2:0] FC_SHORT = 3'd4;
  localparam logic [2:0] FC_WDOG  = 3'd5;

  typedef enum logic {
    MON = 1'b0,
    FLT = 1'b1
  } tlc_state_e;

  function automatic logic is_onehot3(input logic [2:0] c);
    return (c == LAMP_GRN) || (c == LAMP_YEL) || (c == LAMP_RED);
  endfunction

endpackage

// File: rtl/tlc_flash_gen.sv
// Flash phase generator: phase_on holds for FLASH_HALF cycles, then toggles.
// restart forces a fresh "on" half-period starting on the next cycle.
module tlc_flash_gen #(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_on
);
  localparam int CW = $clog2(FLASH_HALF) + 1;

  logic [CW-1:0] cnt_d, cnt_q;
  logic          phase_d, phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q >= CW'(FLASH_HALF - 1)) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_on = phase_q;

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety monitor between the traffic-light controller and the lamp drivers:
// forwards lamp codes with one register, latches faults and forces flashing red.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int FILT       = 2,
  parameter int MIN_Y      = 3,
  parameter int MAX_HOLD   = 20,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north,
  input  logic [2:0] east,
  input  logic [2:0] south,
  input  logic [2:0] west,
  input  logic       fault_clr,
  output logic [2:0] north_lamp,
  output logic [2:0] east_lamp,
  output logic [2:0] south_lamp,
  output logic [2:0] west_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);
  localparam int FW = $clog2(FILT) + 1;
  localparam int YW = $clog2(MIN_Y) + 1;
  localparam int WW = $clog2(MAX_HOLD) + 1;

  function automatic logic [FW-1:0] sat_f(input logic [FW-1:0] v);
    return (v == '1) ? v : v + FW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_y(input logic [YW-1:0] v);
    return (v == '1) ? v : v + YW'(1);
  endfunction

  function automatic logic [WW-1:0] sat_w(input logic [WW-1:0] v);
    return (v == '1) ? v : v + WW'(1);
  endfunction

  logic [3:0][2:0] in_p0_d, in_p0_q, prev_p1_q, lamps;
  logic            vld_p0_q;
  logic [FW-1:0]   filt_d [4];
  logic [FW-1:0]   filt_q [4];
  logic [YW-1:0]   ycnt_d [4];
  logic [YW-1:0]   ycnt_q [4];
  logic [WW-1:0]   wd_d, wd_q;
  logic [3:0]      grn, ill_hit, skip_hit, short_hit;
  logic            same, wd_hit, conflict;
  logic [2:0]      det_code, code_d, code_q;
  tlc_state_e      state_d, state_q;
  logic            restart, phase_on;

  assign in_p0_d = {west, south, east, north};

  // Stage p0 -> p1: per-approach checks on the registered sample vs. the one before it
  for (genvar i = 0; i < 4; i++) begin : g_appr
    logic ill;
    assign ill          = !is_onehot3(in_p0_q[i]);
    assign grn[i]       = (in_p0_q[i] == LAMP_GRN);
    assign ill_hit[i]   = ill && (filt_q[i] >= FW'(FILT - 1));
    assign skip_hit[i]  = (prev_p1_q[i] == LAMP_GRN) && (in_p0_q[i] == LAMP_RED);
    assign short_hit[i] = (prev_p1_q[i] == LAMP_YEL) && (in_p0_q[i] == LAMP_RED)
                          && (ycnt_q[i] < YW'(MIN_Y));

    always_comb begin
      filt_d[i] = filt_q[i];
      ycnt_d[i] = ycnt_q[i];
      if (vld_p0_q) begin
        filt_d[i] = ill ? sat_f(filt_q[i]) : '0;
        if (in_p0_q[i] != LAMP_YEL)        ycnt_d[i] = '0;
        else if (prev_p1_q[i] == LAMP_YEL) ycnt_d[i] = sat_y(ycnt_q[i]);
        else                               ycnt_d[i] = YW'(1);
      end
    end
  end

  // wd_q counts unchanged sample pairs, so MAX_HOLD equal samples = MAX_HOLD-1 pairs
  assign same     = (in_p0_q == prev_p1_q);
  assign wd_hit   = same && (wd_q >= WW'(MAX_HOLD - 2));
  assign conflict = (grn & (grn - 4'd1)) != 4'd0;
  assign wd_d     = !vld_p0_q ? wd_q : (same ? sat_w(wd_q) : '0);

  always_comb begin
    det_code = FC_NONE;
    if (vld_p0_q) begin
      if (conflict)        det_code = FC_GRN;
      else if (|ill_hit)   det_code = FC_ILL;
      else if (|skip_hit)  det_code = FC_SKIP;
      else if (|short_hit) det_code = FC_SHORT;
      else if (wd_hit)     det_code = FC_WDOG;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    restart = 1'b0;
    case (state_q)
      MON: if (det_code != FC_NONE) begin
        state_d = FLT;
        code_d  = det_code;
        restart = 1'b1;
      end
      FLT: if (fault_clr && (det_code == FC_NONE)) begin
        state_d = MON;
        code_d  = FC_NONE;
      end
      default: state_d = MON;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_p0_q   <= {4{LAMP_RED}};
      prev_p1_q <= {4{LAMP_RED}};
      vld_p0_q  <= 1'b0;
      wd_q      <= '0;
      state_q   <= MON;
      code_q    <= FC_NONE;
      for (int i = 0; i < 4; i++) begin
        filt_q[i] <= '0;
        ycnt_q[i] <= '0;
      end
    end else begin
      in_p0_q   <= in_p0_d;
      prev_p1_q <= in_p0_q;
      vld_p0_q  <= 1'b1;
      wd_q      <= wd_d;
      state_q   <= state_d;
      code_q    <= code_d;
      for (int i = 0; i < 4; i++) begin
        filt_q[i] <= filt_d[i];
        ycnt_q[i] <= ycnt_d[i];
      end
    end
  end

  tlc_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .phase_on (phase_on)
  );

  always_comb begin
    lamps = in_p0_q;
    if (state_q == FLT) lamps = {4{phase_on ? LAMP_RED : LAMP_OFF}};
  end

  assign north_lamp = lamps[0];
  assign east_lamp  = lamps[1];
  assign south_lamp = lamps[2];
  assign west_lamp  = lamps[3];
  assign fault      = (state_q == FLT);
  assign flash      = (state_q == FLT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: directed scenarios plus random traffic,
// every output compared each cycle with a rule-level reference model.
module tb_tlc_conflict_monitor;
  localparam int FILT = 2, MIN_Y = 3, MAX_HOLD = 20, FLASH_HALF = 4;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, D = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] north = R, east = R, south = R, west = R;
  logic       fault_clr = 1'b0;
  logic [2:0] north_lamp, east_lamp, south_lamp, west_lamp;
  logic       fault, flash;
  logic [2:0] fault_code;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [2:0] m_cur [4];
  logic [2:0] m_prev [4];
  int         m_yrun [4];
  int         m_ill [4];
  int         m_run, m_code, m_fcnt;
  bit         m_vld, m_fault;

  tlc_conflict_monitor #(.FILT(FILT), .MIN_Y(MIN_Y), .MAX_HOLD(MAX_HOLD),
                         .FLASH_HALF(FLASH_HALF)) dut (
    .clk(clk), .rst(rst), .north(north), .east(east), .south(south), .west(west),
    .fault_clr(fault_clr), .north_lamp(north_lamp), .east_lamp(east_lamp),
    .south_lamp(south_lamp), .west_lamp(west_lamp), .fault(fault),
    .fault_code(fault_code), .flash(flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_lamp(input int i);
    if (!m_fault) return m_cur[i];
    return (((m_fcnt / FLASH_HALF) % 2) == 0) ? R : D;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".north_lamp"}, 32'(north_lamp), 32'(exp_lamp(0)));
    chk({tag, ".east_lamp"},  32'(east_lamp),  32'(exp_lamp(1)));
    chk({tag, ".south_lamp"}, 32'(south_lamp), 32'(exp_lamp(2)));
    chk({tag, ".west_lamp"},  32'(west_lamp),  32'(exp_lamp(3)));
    chk({tag, ".fault"},      32'(fault),      32'(m_fault));
    chk({tag, ".fault_code"}, 32'(fault_code), 32'(m_code));
    chk({tag, ".flash"},      32'(flash),      32'(m_fault));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = R; m_prev[i] = R; m_yrun[i] = 0; m_ill[i] = 0;
    end
    m_run = 1; m_code = 0; m_fcnt = 0; m_vld = 0; m_fault = 0;
  endtask

  // Applies the safety rules to the sample captured last edge, then latches the new one.
  task automatic model_edge(input logic [2:0] n, e, s, w, input logic clr);
    int det, greens;
    bit ill, skip, short_y, unchanged;
    det = 0; greens = 0; ill = 0; skip = 0; short_y = 0; unchanged = 1;
    if (m_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (m_cur[i] == G) greens++;
        if ($countones(m_cur[i]) != 1) begin
          m_ill[i]++;
          if (m_ill[i] >= FILT) ill = 1;
        end else m_ill[i] = 0;
        if (m_prev[i] == G && m_cur[i] == R) skip = 1;
        if (m_prev[i] == Y && m_cur[i] == R && m_yrun[i] < MIN_Y) short_y = 1;
        if (m_cur[i] == Y) m_yrun[i] = (m_prev[i] == Y) ? m_yrun[i] + 1 : 1;
        else m_yrun[i] = 0;
        if (m_cur[i] != m_prev[i]) unchanged = 0;
      end
      m_run = unchanged ? m_run + 1 : 1;
      if (greens > 1)            det = 1;
      else if (ill)              det = 2;
      else if (skip)             det = 3;
      else if (short_y)          det = 4;
      else if (m_run >= MAX_HOLD) det = 5;
    end
    if (!m_fault) begin
      if (det != 0) begin m_fault = 1; m_code = det; m_fcnt = 0; end
    end else if (clr && det == 0) begin
      m_fault = 0; m_code = 0;
    end else begin
      m_fcnt++;
    end
    for (int i = 0; i < 4; i++) m_prev[i] = m_cur[i];
    m_cur[0] = n; m_cur[1] = e; m_cur[2] = s; m_cur[3] = w;
    m_vld = 1;
  endtask

  task automatic tick(input logic [2:0] n, e, s, w, input logic clr, input string tag);
    @(negedge clk);
    north = n; east = e; south = s; west = w; fault_clr = clr;
    model_edge(n, e, s, w, clr);
    @(posedge clk);
    #1 check_outputs(tag);
  endtask

  task automatic ticks(input int cnt, input logic [2:0] n, e, s, w, input string tag);
    for (int k = 0; k < cnt; k++) tick(n, e, s, w, 1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; fault_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1 check_outputs("reset");
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] v [4];
    logic [2:0] rv [4];
    int r;

    // reset and a full legal controller cycle N->E->S->W
    do_reset();
    for (int a = 0; a < 4; a++) begin
      for (int c = 0; c < 15; c++) begin
        for (int i = 0; i < 4; i++) v[i] = R;
        v[a] = (c < 12) ? G : Y;
        tick(v[0], v[1], v[2], v[3], 1'b0, "legal");
      end
    end
    ticks(2, G, R, R, R, "legal");
    chk("legal_no_fault", 32'(fault), 32'd0);

    // green conflict, ignored clear, flash pattern, accepted clear
    do_reset();
    ticks(2, G, R, R, R, "pre_conf");
    ticks(2, G, G, R, R, "conf");
    chk("conf_code", 32'(fault_code), 32'd1);
    tick(G, G, R, R, 1'b1, "clr_ignored");
    chk("clr_ignored_fault", 32'(fault), 32'd1);
    ticks(10, G, G, R, R, "flash");
    tick(G, Y, R, R, 1'b0, "conf_gone");
    tick(G, Y, R, R, 1'b1, "clr_ok");
    chk("clr_ok_fault", 32'(fault), 32'd0);
    chk("clr_ok_passthru", 32'(east_lamp), 32'(Y));
    ticks(2, G, Y, R, R, "resume");
    ticks(3, G, G, R, R, "conf2");
    chk("conf2_fault", 32'(fault), 32'd1);
    do_reset();
    chk("rst_mid_flash_lamp", 32'(north_lamp), 32'(R));

    // illegal code filter
    do_reset();
    ticks(2, R, R, R, R, "ill_pre");
    ticks(1, R, R, 3'b011, R, "ill_1");
    ticks(3, R, R, R, R, "ill_post");
    chk("ill_short_no_fault", 32'(fault), 32'd0);
    ticks(2, R, R, 3'b011, R, "ill_2");
    ticks(2, R, R, R, R, "ill_post2");
    chk("ill_code", 32'(fault_code), 32'd2);

    // skipped yellow
    do_reset();
    ticks(3, R, R, R, G, "skip_g");
    ticks(2, R, R, R, R, "skip_r");
    chk("skip_code", 32'(fault_code), 32'd3);

    // minimum yellow boundary then short yellow
    do_reset();
    ticks(2, R, G, R, R, "y3_g");
    ticks(3, R, Y, R, R, "y3_y");
    ticks(2, R, R, R, R, "y3_r");
    chk("y3_no_fault", 32'(fault), 32'd0);
    ticks(2, R, G, R, R, "y2_g");
    ticks(2, R, Y, R, R, "y2_y");
    ticks(2, R, R, R, R, "y2_r");
    chk("short_code", 32'(fault_code), 32'd4);

    // conflict and skipped yellow together
    do_reset();
    ticks(2, R, R, R, G, "both_pre");
    ticks(2, G, G, R, R, "both");
    chk("both_code", 32'(fault_code), 32'd1);

    // watchdog boundary
    do_reset();
    ticks(19, G, R, R, R, "wd19");
    ticks(2, Y, R, R, R, "wd19_y");
    chk("wd19_no_fault", 32'(fault), 32'd0);
    ticks(1, Y, R, R, R, "wd19_y");
    ticks(21, R, G, R, R, "wd20");
    chk("wd_code", 32'(fault_code), 32'd5);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4; i++) rv[i] = R;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) < 2) begin
          r = $urandom_range(0, 9);
          rv[i] = (r < 3) ? G : (r < 6) ? Y : (r < 9) ? R : 3'($urandom_range(0, 7));
        end
      end
      tick(rv[0], rv[1], rv[2], rv[3], ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
- Safety stage directly downstream of the four-way traffic-light controller.
- Consumes its per-approach lamp codes and forwards them to the lamp drivers with a 1-cycle register.
- Checks the lamp codes every cycle for unsafe patterns. On any fault it latches a fault code and overrides all approaches to flashing red until a clear is accepted.

Parameters:
- FILT, 2: consecutive cycles an illegal lamp code must persist before it faults.
- MIN_Y, 3: minimum yellow interval (cycles) before a yellow→red transition is legal.
- MAX_HOLD, 20: maximum cycles all four inputs may stay unchanged before watchdog fault.
- FLASH_HALF, 4: cycles per flash half-period.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- north, east, south, west  input  3 each  controller lamp codes: 3'b001 green, 3'b010 yellow, 3'b100 red.
- fault_clr  input  1  request to clear a latched fault.
- north_lamp, east_lamp, south_lamp, west_lamp  output  3 each  lamp drive, same encoding; 3'b000 = dark.
- fault  output  1  latched fault flag.
- fault_code  output  3  0 none, 1 green conflict, 2 illegal code, 3 skipped yellow, 4 short yellow, 5 watchdog.
- flash  output  1  high while in flash override.

Behaviour:
- Reset (rst==0 at a clock edge):
  - all *_lamp = 3'b100; fault=0, fault_code=0, flash=0.
  - previous-code registers = 3'b100; yellow counters, illegal filters, watchdog and flash counters = 0.
- Normal mode (fault==0):
  - *_lamp = input code sampled at the previous edge; latency exactly 1 cycle.
- Checks, evaluated on the inputs sampled at edge k; any fault shows in fault/fault_code after edge k+1:
  - Green conflict: more than one input == 3'b001.
  - Illegal code: an input not one-hot, for FILT consecutive cycles. Each approach has its own filter, reset when that input is legal.
  - Skipped yellow: previous code green, current code red.
  - Short yellow: previous code yellow, current red, and the yellow-run count < MIN_Y.
    - Yellow-run counter: set to 1 on entering yellow, +1 while yellow, saturating.
    - Yellow→green is legal and is not checked.
  - Watchdog: the 12-bit concatenation of all inputs is unchanged for MAX_HOLD consecutive cycles. The counter resets on any change.
- Simultaneous detections: fault_code = the lowest-numbered code.
- Fault latch:
  - fault and fault_code are sticky; later detections do not overwrite the code.
  - flash asserts on the same edge as fault.
- Flash mode:
  - all four lamps = 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating.
  - phase begins "on" (red) on the edge fault asserts.
  - Checks and previous-code tracking keep running during flash.
- Clear:
  - fault_clr==1 at an edge with no check firing on that edge's inputs clears fault, fault_code and flash.
  - The next cycle resumes pass-through.
  - fault_clr while a check is firing is ignored, and the fault remains.
  - fault_clr with no fault latched has no effect.
- Reset mid-flash: the reset values above win immediately.
- State machine, 2 states:
  - MON → FLT on any detection.
  - FLT → MON on an accepted clear.
- Widths: counters sized by $clog2 of their parameter + 1, all saturating, no wrap.

Decomposition:
- Shared package tlc_pkg:
  - lamp encodings LAMP_GRN/LAMP_YEL/LAMP_RED/LAMP_OFF.
  - fault code constants FC_NONE..FC_WDOG.
  - state enum MON/FLT.
  - The controller adopts the same lamp constants.
- One sub-module tlc_flash_gen (FLASH_HALF counter plus phase toggle, with sync restart input), instantiated once.
- Per-approach check logic is generated four times inside the block, not a separate module.

Test Plan:
- Drive a full legal controller cycle (G 12, Y 3 per approach, sequence N→E→S→W) → lamps track inputs with 1-cycle delay, fault stays 0 throughout.
- north=001 and east=001 on the same cycle → next edge fault=1, fault_code=1, all lamps 100 for 4 cycles, then 000 for 4, repeating.
- south=3'b011 for 1 cycle then legal → no fault; south=3'b011 for 2 cycles → fault_code=2.
- west 001→100 directly → fault_code=3. Separate run: east yellow for 2 cycles then red → fault_code=4. Also assert conflict and skipped yellow together → fault_code=1.
- Hold all inputs constant 19 cycles → no fault; 20 cycles → fault_code=5.
- In flash: fault_clr while conflict persists → still fault; remove conflict, pulse fault_clr → fault=0 next cycle, pass-through resumes. Then assert rst=0 mid-flash in a new fault → lamps 100, fault 0 after that edge.
